// File: rtl/fault_log_pkg.sv
// Shared constants for the fault event logger: source bit map, fatal mask
// and the event entry width helper.
package fault_log_pkg;

  localparam int SRC_S_IMEM = 0;
  localparam int SRC_D_IMEM = 1;
  localparam int SRC_S_DMEM = 2;
  localparam int SRC_D_DMEM = 3;
  localparam int SRC_HW     = 4;
  localparam int SRC_MUX    = 5;

  // Uncorrectable ECC (bits 1, 3) and ALU hardware fault (bit 4) are fatal.
  localparam logic [5:0] FATAL_MASK = 6'b011010;

  function automatic int ENTRY_W(input int ts_w, input int num_src);
    return ts_w + num_src;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with separate level tracking; push while full is accepted
// only when a pop frees the head slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      lvl_q, lvl_d;
  logic             do_push, do_pop;

  assign full  = (lvl_q == (AW+1)'(DEPTH));
  assign empty = (lvl_q == '0);
  assign dout  = mem_q[rd_q];
  assign level = lvl_q;

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      // When full, wr_q == rd_q: the write lands in the slot being popped.
      if (do_push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/fault_event_logger.sv
// Converts pipeline fault levels into timestamped rise events, with sticky
// status, per-source saturating counters and a drainable event FIFO.
module fault_event_logger
  import fault_log_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int DEPTH   = 8,
  parameter int TS_W    = 16,
  parameter int CNT_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           err_in,
  input  logic                         clear_i,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [TS_W+NUM_SRC-1:0]      evt_data,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic [NUM_SRC-1:0]           sticky_o,
  input  logic [$clog2(NUM_SRC)-1:0]   cnt_sel,
  output logic [CNT_W-1:0]             cnt_o,
  output logic                         overflow_o,
  output logic [CNT_W-1:0]             drop_cnt_o,
  output logic                         fatal_o
);

  localparam int EW    = ENTRY_W(TS_W, NUM_SRC);
  localparam int SEL_W = $clog2(NUM_SRC);
  localparam logic [NUM_SRC-1:0] FMASK = NUM_SRC'(FATAL_MASK);

  logic [TS_W-1:0]    ts_q, ts_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [CNT_W-1:0]   cnt_d [NUM_SRC];
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               fatal_q, fatal_d;

  logic [NUM_SRC-1:0] rise;
  logic               fire, pop, drop;
  logic               fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear_i),
    .push  (fire),
    .pop   (pop),
    .din   ({ts_q, rise}),
    .dout  (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    rise     = err_in & ~prev_q;
    fire     = (|rise) & ~clear_i;
    pop      = ~fifo_empty & evt_ready & ~clear_i;
    drop     = fire & fifo_full & ~pop;
    ts_d     = ts_q + 1'b1;
    prev_d   = err_in;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (clear_i) begin
      sticky_d = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_d[i] = '0;
      ovf_d    = 1'b0;
      drop_d   = '0;
    end else begin
      sticky_d = sticky_q | rise;
      for (int unsigned i = 0; i < NUM_SRC; i++)
        if (rise[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + 1'b1;
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + 1'b1;
      end
    end
    fatal_d = |(sticky_d & FMASK);
  end

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (cnt_sel == SEL_W'(i)) cnt_o = cnt_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q     <= '0;
      prev_q   <= '0;
      sticky_q <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      fatal_q  <= 1'b0;
    end else begin
      ts_q     <= ts_d;
      prev_q   <= prev_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      fatal_q  <= fatal_d;
    end
  end

  assign evt_valid  = ~fifo_empty;
  assign sticky_o   = sticky_q;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_q;
  assign fatal_o    = fatal_q;

endmodule

// File: tb/tb_fault_event_logger.sv
// Self-checking bench: queue-based event model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_fault_event_logger;

  localparam int NSRC  = 6;
  localparam int DEP   = 8;
  localparam int TSW   = 16;
  localparam int CW    = 8;

  logic            clk = 0;
  logic            rst = 1;
  logic [NSRC-1:0] err_in = '0;
  logic            clear_i = 0;
  logic            evt_valid;
  logic            evt_ready = 0;
  logic [TSW+NSRC-1:0] evt_data;
  logic [3:0]      fifo_level;
  logic [NSRC-1:0] sticky_o;
  logic [2:0]      cnt_sel = '0;
  logic [CW-1:0]   cnt_o;
  logic            overflow_o;
  logic [CW-1:0]   drop_cnt_o;
  logic            fatal_o;

  int checks = 0;
  int errors = 0;

  fault_event_logger #(
    .NUM_SRC (NSRC),
    .DEPTH   (DEP),
    .TS_W    (TSW),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .err_in     (err_in),
    .clear_i    (clear_i),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .fifo_level (fifo_level),
    .sticky_o   (sticky_o),
    .cnt_sel    (cnt_sel),
    .cnt_o      (cnt_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o),
    .fatal_o    (fatal_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int                  m_ts;
  logic [NSRC-1:0]     m_prev;
  logic [NSRC-1:0]     m_sticky;
  int                  m_cnt [NSRC];
  bit                  m_ovf;
  int                  m_drop;
  logic [TSW+NSRC-1:0] m_q [$];

  function automatic void model_reset();
    m_ts = 0; m_prev = '0; m_sticky = '0; m_ovf = 0; m_drop = 0;
    for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
    m_q.delete();
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    if (rst) model_reset();
    else begin
      logic [NSRC-1:0] r;
      r = err_in & ~m_prev;
      if (clear_i) begin
        m_sticky = '0; m_ovf = 0; m_drop = 0; m_q.delete();
        for (int i = 0; i < NSRC; i++) m_cnt[i] = 0;
      end else begin
        if (m_q.size() != 0 && evt_ready) void'(m_q.pop_front());
        if (r != 0) begin
          if (m_q.size() < DEP) m_q.push_back({TSW'(m_ts), r});
          else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
          end
        end
        m_sticky |= r;
        for (int i = 0; i < NSRC; i++)
          if (r[i] && m_cnt[i] < 255) m_cnt[i]++;
      end
      m_prev = err_in;
      m_ts = (m_ts + 1) % 65536;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("evt_valid", 32'(evt_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("evt_data", 32'(evt_data), 32'(m_q[0]));
    chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
    chk("sticky", 32'(sticky_o), 32'(m_sticky));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
    chk("fatal", 32'(fatal_o), 32'(|(m_sticky & 6'b011010)));
    chk("cnt_o", 32'(cnt_o), (cnt_sel < NSRC) ? 32'(m_cnt[cnt_sel]) : 32'd0);
  end

  // ---------------- driver / directed checks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic lit_cnt(input int sel, input int exp);
    cnt_sel = 3'(sel);
    #1;
    chk($sformatf("cnt_lit[%0d]", sel), 32'(cnt_o), 32'(exp));
  endtask

  task automatic pulse(input logic [NSRC-1:0] m);
    err_in = m; step(1);
    err_in = '0; step(1);
  endtask

  initial begin
    int last_ts;
    int pops;
    step(2);
    rst = 0;

    // idle after reset
    step(20);
    chk("idle_valid", 32'(evt_valid), 0);
    chk("idle_sticky", 32'(sticky_o), 0);
    chk("idle_fatal", 32'(fatal_o), 0);
    chk("idle_level", 32'(fifo_level), 0);
    for (int i = 0; i < 8; i++) lit_cnt(i, 0);

    // second reset so the timestamp restarts from 0
    rst = 1; model_reset(); step(1); rst = 0;
    for (int i = 0; i < 40 && m_ts != 10; i++) step(1);
    chk("ts_align", 32'(m_ts), 10);
    err_in = 6'b000100; step(1); err_in = '0;
    chk("pulse_valid", 32'(evt_valid), 1);
    chk("pulse_data", 32'(evt_data), 32'({16'd10, 6'b000100}));
    chk("pulse_sticky", 32'(sticky_o), 32'h04);
    chk("pulse_fatal", 32'(fatal_o), 0);
    lit_cnt(2, 1);

    // held level -> single event
    err_in = 6'b010000; step(5); err_in = '0; step(1);
    chk("held_level", 32'(fifo_level), 2);
    chk("held_fatal", 32'(fatal_o), 1);
    lit_cnt(4, 1);

    // simultaneous rises -> one entry
    err_in = 6'b101000; step(1); err_in = '0;
    chk("simul_level", 32'(fifo_level), 3);
    lit_cnt(3, 1);
    lit_cnt(5, 1);

    // plain clear
    clear_i = 1; step(1); clear_i = 0;
    chk("clr_level", 32'(fifo_level), 0);
    chk("clr_sticky", 32'(sticky_o), 0);
    chk("clr_fatal", 32'(fatal_o), 0);

    // clear together with a rise; held level must not re-fire
    err_in = 6'b000001; clear_i = 1; step(1); clear_i = 0; step(2);
    chk("clrrise_sticky", 32'(sticky_o), 0);
    chk("clrrise_level", 32'(fifo_level), 0);
    lit_cnt(0, 0);
    err_in = '0; step(1);

    // overflow: 10 pulses without draining
    evt_ready = 0;
    for (int i = 0; i < 10; i++) pulse(6'b000001);
    chk("ovf_level", 32'(fifo_level), 8);
    chk("ovf_flag", 32'(overflow_o), 1);
    chk("ovf_drop", 32'(drop_cnt_o), 2);
    lit_cnt(0, 10);
    evt_ready = 1;
    last_ts = -1; pops = 0;
    for (int i = 0; i < 20 && evt_valid; i++) begin
      chk("drain_mask", 32'(evt_data[NSRC-1:0]), 32'h01);
      if (int'(evt_data[TSW+NSRC-1:NSRC]) <= last_ts)
        chk("drain_order", 32'(evt_data[TSW+NSRC-1:NSRC]), 32'(last_ts + 1));
      last_ts = int'(evt_data[TSW+NSRC-1:NSRC]);
      pops++;
      step(1);
    end
    chk("drain_pops", 32'(pops), 8);
    chk("drain_empty", 32'(evt_valid), 0);

    // counter saturation
    for (int i = 0; i < 300; i++) pulse(6'b000010);
    lit_cnt(1, 255);

    // randomized traffic with occasional clear and reset
    for (int n = 0; n < 3000; n++) begin
      err_in    = err_in ^ NSRC'($urandom & $urandom & $urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      clear_i   = ($urandom_range(0, 99) == 0);
      cnt_sel   = 3'($urandom_range(0, 7));
      if (n % 900 == 450) begin
        rst = 1; model_reset(); #1;
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_data", 32'(evt_data), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_sticky", 32'(sticky_o), 0);
        chk("rst_ovf", 32'(overflow_o), 0);
        chk("rst_drop", 32'(drop_cnt_o), 0);
        chk("rst_fatal", 32'(fatal_o), 0);
        chk("rst_cnt", 32'(cnt_o), 0);
        step(1); rst = 0;
      end
      step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
